// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Register file with two combinational read ports and one synchronous write
//   port. Storage covers R0-R14 only; address 15 reads the PC+8 value that
//   the fetch stage drives on r15, so it has no storage.
//
//   Optional build macro: REG_FILE_BYPASS_EN
//     defined   : write-through bypass. A read of the address currently being
//                 written returns wd3 in the same cycle.
//     undefined : no bypass. A read of the address being written returns the
//                 old value until the clock edge.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst_n in   1      asynchronous active-low reset, clears R0-R14
//   we3   in   1      write enable for write port 3
//   a1    in   4      read address, port 1
//   a2    in   4      read address, port 2
//   a3    in   4      write address (15 is ignored)
//   wd3   in   WIDTH  write data
//   r15   in   WIDTH  PC+8 from fetch, returned for read address 15
//   rd1   out  WIDTH  read data port 1 (ALU source A)
//   rd2   out  WIDTH  read data port 2 (ALU source B mux)
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [3:0]       a1,
  input  logic [3:0]       a2,
  input  logic [3:0]       a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  localparam int         NUM_REGS = 15;
  localparam logic [3:0] PC_ADDR  = 4'd15;

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             wr_ok;
  logic [WIDTH-1:0] rd1_store;
  logic [WIDTH-1:0] rd2_store;

  // Writes to address 15 are dropped here so the storage array is never
  // indexed out of range.
  assign wr_ok = we3 && (a3 != PC_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (a3 == 4'(i)) begin
          regs[i] <= wd3;
        end
      end
    end
  end

  // Decoded read muxes; address 15 never matches a storage slot, so the
  // store value defaults to zero and the r15 selection below takes over.
  always_comb begin
    rd1_store = '0;
    rd2_store = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a1 == 4'(i)) rd1_store = regs[i];
      if (a2 == 4'(i)) rd2_store = regs[i];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Bypass needs reset released and a real storage address; a read of 15
  // always sees r15.
  assign byp1 = rst_n && wr_ok && (a1 == a3);
  assign byp2 = rst_n && wr_ok && (a2 == a3);

  always_comb begin
    if (a1 == PC_ADDR)   rd1 = r15;
    else if (byp1)       rd1 = wd3;
    else                 rd1 = rd1_store;

    if (a2 == PC_ADDR)   rd2 = r15;
    else if (byp2)       rd2 = wd3;
    else                 rd2 = rd2_store;
  end
`else
  always_comb begin
    rd1 = (a1 == PC_ADDR) ? r15 : rd1_store;
    rd2 = (a2 == PC_ADDR) ? r15 : rd2_store;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         we3;
  logic [3:0]   a1, a2, a3;
  logic [W-1:0] wd3, r15, rd1, rd2;

  reg_file #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .we3(we3),
    .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .r15(r15), .rd1(rd1), .rd2(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    bit           port;
    logic [W-1:0] exp;
  } exp_t;

  exp_t         sb[$];
  event         sample_ev;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model [15];

`ifdef REG_FILE_BYPASS_EN
  localparam logic [W-1:0] SAME_CYCLE_R7 = 32'h2;
`else
  localparam logic [W-1:0] SAME_CYCLE_R7 = 32'h1;
`endif

  // Monitor: pops every queued expectation once the read ports have settled.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [W-1:0] act;
        e   = sb.pop_front();
        act = e.port ? rd2 : rd1;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: rd%0d got %h expected %h", e.name, e.port ? 2 : 1, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic sample();
    -> sample_ev;
    #2;
  endtask

  task automatic chk1(input logic [3:0] a, input logic [W-1:0] e, input string n);
    a1 = a;
    sb.push_back('{n, 1'b0, e});
    sample();
  endtask

  task automatic chk2(input logic [3:0] a, input logic [W-1:0] e, input string n);
    a2 = a;
    sb.push_back('{n, 1'b1, e});
    sample();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we3 = 1'b1; a3 = a; wd3 = d;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    if (a != 4'd15) model[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 15; i++) model[i] = '0;
  endtask

  task automatic check_all(input string n);
    for (int i = 0; i < 15; i++) chk1(4'(i), model[i], n);
  endtask

  initial begin
    rst_n = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0;
    wd3 = '0; r15 = 32'h0000_0108;
    model_clear();
    #1 rst_n = 1'b0;
    #3;
    chk1(4'd0,  32'h0, "reset_r0");
    chk2(4'd14, 32'h0, "reset_r14");
    chk1(4'd15, 32'h0000_0108, "reset_r15_path");
    @(negedge clk);
    rst_n = 1'b1;

    // Write R3 then assert reset mid-cycle: clears with no clock edge
    do_write(4'd3, 32'hDEAD_BEEF);
    chk1(4'd3, 32'hDEAD_BEEF, "r3_written");
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    chk1(4'd3, 32'h0, "async_reset_r3");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read on both ports
    do_write(4'd5, 32'h1234_5678);
    chk1(4'd5, 32'h1234_5678, "wr5_rd1");
    chk2(4'd5, 32'h1234_5678, "wr5_rd2");
    do_write(4'd0,  32'h0F0F_0F0F);
    do_write(4'd14, 32'hE0E0_E0E0);
    do_write(4'd1,  32'h1111_1111);
    chk1(4'd14, 32'hE0E0_E0E0, "wr14_rd1");
    chk2(4'd1,  32'h1111_1111, "wr1_rd2");
    chk1(4'd0,  32'h0F0F_0F0F, "wr0_rd1");

    // Write to 15 ignored; r15 path unaffected, bypass never applies there
    @(negedge clk);
    r15 = 32'h0000_0108; we3 = 1'b1; a3 = 4'd15; wd3 = 32'hFFFF_FFFF;
    chk1(4'd15, 32'h0000_0108, "r15_same_cycle");
    @(posedge clk);
    #1 we3 = 1'b0;
    chk1(4'd15, 32'h0000_0108, "r15_after_edge");
    check_all("wr15_no_change");
    r15 = 32'hCAFE_0010;
    chk2(4'd15, 32'hCAFE_0010, "r15_follows_input");

    // Write disable
    @(negedge clk);
    we3 = 1'b0; a3 = 4'd2; wd3 = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    chk2(4'd2, 32'h0, "we3_low_r2");

    // Same-cycle read of the write address
    do_write(4'd7, 32'h1);
    @(negedge clk);
    we3 = 1'b1; a3 = 4'd7; wd3 = 32'h2;
    chk1(4'd7, SAME_CYCLE_R7, "same_cycle_rd1");
    chk2(4'd7, SAME_CYCLE_R7, "same_cycle_rd2");
    chk2(4'd5, 32'h1234_5678, "same_cycle_other");
    @(posedge clk);
    #1 we3 = 1'b0;
    model[7] = 32'h2;
    chk1(4'd7, 32'h2, "after_edge_r7");

    // Reset held across a write edge wins
    @(negedge clk);
    rst_n = 1'b0; we3 = 1'b1; a3 = 4'd4; wd3 = 32'h55;
    model_clear();
    chk1(4'd4, 32'h0, "rst_wr_during");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; we3 = 1'b0;
    chk1(4'd4, 32'h0, "rst_wins_r4");

    // First edge after reset release performs a normal write
    do_write(4'd4, 32'h77);
    chk1(4'd4, 32'h77, "first_write_after_reset");
    check_all("final_sweep");

    #10;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
